// File: rtl/belt_warn_timer.sv
// Seat-belt warning front end: input sync/debounce, 1 s prescaler and warning FSM.
// Optional buzzer drive is compiled in with `define BELT_WARN_BEEP_EN.
module belt_warn_timer #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int DEB_LEN   = 16,
    parameter int WARN_SEC  = 5,
    parameter int ALERT_SEC = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       p_i,
    input  logic       ns_i,
    input  logic       k_i,
    output logic       t_o,
    output logic [7:0] second_o,
    output logic [1:0] state_o,
    output logic       beep_o
);

    localparam int DW = $clog2(DEB_LEN + 1);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [7:0] WARN_S = 8'(WARN_SEC);
    localparam logic [7:0] END_S  = 8'(WARN_SEC + ALERT_SEC);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        ALERT = 2'b10,
        HOLD  = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    raw, s1, s2, deb, deb_nxt;
    logic [DW-1:0] deb_cnt [3];
    logic [DW-1:0] cnt_nxt [3];
    logic          cond;

    assign raw = {p_i, ns_i, k_i};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_nxt[i] = deb[i];
            cnt_nxt[i] = '0;
            if (s2[i] != deb[i]) begin
                if (deb_cnt[i] == DW'(DEB_LEN - 1)) deb_nxt[i] = s2[i];
                else                                cnt_nxt[i] = deb_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            deb <= deb_nxt;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= cnt_nxt[i];
        end
    end

    // The FSM acts on the level being accepted this edge, so it moves on the same edge.
    assign cond = &deb_nxt;

    logic [PW-1:0] pre_cnt;
    logic          sec_tick;

    assign sec_tick = (pre_cnt == PW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                pre_cnt <= '0;
        else if (state == IDLE)   pre_cnt <= '0;
        else if (sec_tick)        pre_cnt <= '0;
        else                      pre_cnt <= pre_cnt + 1'b1;
    end

    logic [7:0] sec_inc, second_nxt;
    logic       t_nxt;

    assign sec_inc = (second_o == 8'hFF) ? 8'hFF : second_o + 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            t_o      <= 1'b0;
            second_o <= 8'd0;
        end else begin
            state    <= state_nxt;
            t_o      <= t_nxt;
            second_o <= second_nxt;
        end
    end

    // A dropped cond always wins over a coincident tick.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cond) state_nxt = ARMED;
            ARMED: begin
                if (!cond) state_nxt = IDLE;
                else if (WARN_SEC == 0 || (sec_tick && sec_inc == WARN_S)) state_nxt = ALERT;
            end
            ALERT: begin
                if (!cond) state_nxt = IDLE;
                else if (sec_tick && sec_inc == END_S) state_nxt = HOLD;
            end
            HOLD:  if (!cond) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        second_nxt = second_o;
        t_nxt      = (state_nxt == ALERT);
        if (state_nxt == IDLE)
            second_nxt = 8'd0;
        else if ((state == ARMED || state == ALERT) && sec_tick)
            second_nxt = sec_inc;
    end

    assign state_o = state;

`ifdef BELT_WARN_BEEP_EN
    logic half_tick, beep_nxt;

    assign half_tick = sec_tick || (pre_cnt == PW'(CLK_DIV / 2 - 1));

    always_comb begin
        beep_nxt = 1'b0;
        if (state_nxt == ALERT) begin
            if (state != ALERT) beep_nxt = 1'b1;
            else if (half_tick) beep_nxt = ~beep_o;
            else                beep_nxt = beep_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) beep_o <= 1'b0;
        else       beep_o <= beep_nxt;
    end
`else
    assign beep_o = 1'b0;
`endif

endmodule

// File: tb/tb_belt_warn_timer.sv
// Directed bench for belt_warn_timer with CLK_DIV=10, DEB_LEN=4, WARN_SEC=5, ALERT_SEC=3.
// Edge numbers in comments count rising edges after each reset release.
module tb_belt_warn_timer;

    logic       clk;
    logic       rst;
    logic       p, ns, k;
    logic       t;
    logic [7:0] second;
    logic [1:0] state;
    logic       beep;

    int total = 0;
    int bad   = 0;

`ifdef BELT_WARN_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    belt_warn_timer #(
        .CLK_DIV  (10),
        .DEB_LEN  (4),
        .WARN_SEC (5),
        .ALERT_SEC(3)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .p_i     (p),
        .ns_i    (ns),
        .k_i     (k),
        .t_o     (t),
        .second_o(second),
        .state_o (state),
        .beep_o  (beep)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic pv, input logic nsv, input logic kv);
        p  = pv;
        ns = nsv;
        k  = kv;
    endtask

    // Holds reset across two edges and releases 1 ns after an edge.
    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_inputs(1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",  8'(state),  8'd0);
        check("rst_t",      8'(t),      8'd0);
        check("rst_second", second,     8'd0);
        check("rst_beep",   8'(beep),   8'd0);
        rst = 1'b0;

        // Scenario A: straight episode through ALERT into HOLD
        wait_edges(5);                                       // edge 5
        check("a_pre_arm",  8'(state), 8'd0);
        wait_edges(1);                                       // edge 6
        check("a_arm",      8'(state), 8'd1);
        check("a_arm_sec",  second,    8'd0);
        wait_edges(9);                                       // edge 15
        check("a_sec_pre1", second,    8'd0);
        wait_edges(1);                                       // edge 16
        check("a_sec1",     second,    8'd1);
        wait_edges(39);                                      // edge 55
        check("a_t_pre",    8'(t),     8'd0);
        check("a_sec4",     second,    8'd4);
        check("a_beep_arm", 8'(beep),  8'd0);
        wait_edges(1);                                       // edge 56
        check("a_t_rise",   8'(t),     8'd1);
        check("a_sec5",     second,    8'd5);
        check("a_alert",    8'(state), 8'd2);
        check("a_beep_in",  8'(beep),  8'(BEEP_ON));
        wait_edges(4);                                       // edge 60
        check("a_beep_60",  8'(beep),  8'(BEEP_ON));
        wait_edges(1);                                       // edge 61
        check("a_beep_61",  8'(beep),  8'd0);
        wait_edges(5);                                       // edge 66
        check("a_beep_66",  8'(beep),  8'(BEEP_ON));
        check("a_sec6",     second,    8'd6);
        wait_edges(19);                                      // edge 85
        check("a_t_hi85",   8'(t),     8'd1);
        check("a_sec7",     second,    8'd7);
        wait_edges(1);                                       // edge 86
        check("a_t_fall",   8'(t),     8'd0);
        check("a_hold",     8'(state), 8'd3);
        check("a_sec8",     second,    8'd8);
        check("a_beep_hold", 8'(beep), 8'd0);
        wait_edges(100);                                     // edge 186
        check("a_sec_frozen", second,  8'd8);
        check("a_hold_stay", 8'(state), 8'd3);
        check("a_t_hold",   8'(t),     8'd0);

        // Scenario B: short ns glitch in ARMED, then async reset mid-ALERT
        apply_reset();
        wait_edges(6);                                       // edge 6
        check("b_arm",      8'(state), 8'd1);
        wait_edges(14);                                      // edge 20
        ns = 1'b0;
        wait_edges(2);                                       // edge 22
        ns = 1'b1;
        wait_edges(33);                                      // edge 55
        check("b_t_pre",    8'(t),     8'd0);
        check("b_armed",    8'(state), 8'd1);
        wait_edges(1);                                       // edge 56
        check("b_t_rise",   8'(t),     8'd1);
        check("b_sec5",     second,    8'd5);
        wait_edges(3);                                       // edge 59
        check("b_beep_59",  8'(beep),  8'(BEEP_ON));
        #3 rst = 1'b1;
        #1;
        check("b_rst_t",     8'(t),     8'd0);
        check("b_rst_sec",   second,    8'd0);
        check("b_rst_state", 8'(state), 8'd0);
        check("b_rst_beep",  8'(beep),  8'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Scenario C: ns low in ALERT drops to IDLE, then a fresh count
        wait_edges(6);                                       // edge 6
        check("c_arm",      8'(state), 8'd1);
        wait_edges(50);                                      // edge 56
        check("c_alert",    8'(state), 8'd2);
        wait_edges(4);                                       // edge 60
        ns = 1'b0;
        wait_edges(5);                                       // edge 65
        check("c_still_alert", 8'(state), 8'd2);
        check("c_t_hi",     8'(t),     8'd1);
        check("c_sec_hi",   second,    8'd5);
        wait_edges(1);                                       // edge 66, coincides with a tick
        check("c_idle",     8'(state), 8'd0);
        check("c_t_lo",     8'(t),     8'd0);
        check("c_sec_clr",  second,    8'd0);
        check("c_beep_lo",  8'(beep),  8'd0);
        wait_edges(4);                                       // edge 70
        ns = 1'b1;
        wait_edges(5);                                       // edge 75
        check("c_pre_rearm", 8'(state), 8'd0);
        wait_edges(1);                                       // edge 76
        check("c_rearm",    8'(state), 8'd1);
        check("c_rearm_sec", second,   8'd0);
        wait_edges(9);                                       // edge 85
        check("c_sec_pre1", second,    8'd0);
        wait_edges(1);                                       // edge 86
        check("c_sec1",     second,    8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/belt_warn_timer.md
# belt_warn_timer

Seat-belt warning front end for the safety-belt alarm path. It synchronizes and debounces the passenger-present, belt-not-fastened and key-on sensors and divides the system clock into one-second ticks. It runs a warning state machine that produces the registered timer-expired flag consumed as `t_i` by the belt alarm stage, and exports the elapsed-seconds count.

## Interface
- `CLK_DIV`, 50_000_000, clock cycles per second; must be ≥ 4 and even.
- `DEB_LEN`, 16, consecutive equal synchronized samples needed to accept a new input level.
- `WARN_SEC`, 5, seconds of continuous unsafe condition before alert.
- `ALERT_SEC`, 30, alert duration in seconds; `WARN_SEC+ALERT_SEC` ≤ 255.

Ports:
- `clk_i` input 1: single system clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `p_i` input 1: passenger present, raw, asynchronous.
- `ns_i` input 1: belt not fastened, raw, asynchronous.
- `k_i` input 1: key on, raw, asynchronous.
- `t_o` output 1: timer-expired/alert flag, registered; drives the alarm stage `t_i`.
- `second_o` output 8: elapsed seconds of the current unsafe episode, registered.
- `state_o` output 2: FSM state (00 IDLE, 01 ARMED, 10 ALERT, 11 HOLD).
- `beep_o` output 1: buzzer drive, registered (see Configuration).

## Operation
- Each raw input passes through a 2-flop synchronizer, then a debouncer. The debounced value changes only after `DEB_LEN` consecutive synchronized samples differ from it.
- `cond` = debounced `p & ns & k`.
- Prescaler counts 0..`CLK_DIV-1`. `sec_tick` is a one-cycle pulse when the count equals `CLK_DIV-1`, and the count wraps to 0. The prescaler is forced to 0 in every cycle the FSM is in IDLE, so the first ARMED second is a full second.
- IDLE: `second_o`=0, `t_o`=0. `cond`=1 → ARMED.
- ARMED: `sec_tick` increments `second_o`. The tick that makes `second_o`==`WARN_SEC` → ALERT. `cond`=0 → IDLE.
- ALERT: `t_o`=1. `sec_tick` keeps incrementing `second_o`. The tick that makes `second_o`==`WARN_SEC+ALERT_SEC` → HOLD. `cond`=0 → IDLE.
- HOLD: `t_o`=0 and `second_o` is frozen; this mutes the alarm until the episode ends. `cond`=0 → IDLE.
- Any transition to IDLE clears `second_o` and `t_o` on the same edge.
- `cond`=0 and `sec_tick` in the same cycle: the drop of `cond` wins, and no increment occurs.
- `second_o` saturates at 255 and never wraps.
- `WARN_SEC`=0: ARMED goes to ALERT on the first edge in ARMED, with no tick required.

## Timing
- Reset values: state IDLE, `t_o`=0, `second_o`=0, `state_o`=00, `beep_o`=0. Debounced inputs are 0, and the synchronizers and prescaler are 0.
- Reset acts immediately on assertion, without a clock edge. The first state change is possible on the first rising edge after deassertion.
- Input-to-`cond` latency: 2 synchronizer cycles + `DEB_LEN` cycles.
- `t_o`, `second_o` and `state_o` update on the same edge as the state transition. There is no extra output pipeline.
- `t_o` rises exactly `WARN_SEC*CLK_DIV` cycles after ARMED entry, and falls `ALERT_SEC*CLK_DIV` cycles after that.
- Reset asserted mid-episode discards all counts. After release the block restarts from IDLE and re-debounces the inputs.

## Configuration
- `BELT_WARN_BEEP_EN` defined:
  - Half-second ticks occur at prescaler count `CLK_DIV/2-1` and `CLK_DIV-1`.
  - In ALERT, `beep_o` toggles on each half-second tick.
  - On entry to ALERT, `beep_o` is set to 1.
  - In every other state `beep_o` is 0.
- `BELT_WARN_BEEP_EN` undefined: the beep logic is not compiled, and `beep_o` is tied to constant 0.

## Test plan
Bench parameters: `CLK_DIV`=10, `DEB_LEN`=4, `WARN_SEC`=5, `ALERT_SEC`=3.
- Inputs p/ns/k high from reset release → `state_o`=01 after 6 cycles. `t_o` rises 50 cycles after ARMED entry with `second_o`=5 and `state_o`=10.
- Hold inputs high → `t_o` falls 30 cycles after rising, with `state_o`=11 and `second_o`=8. `second_o` stays 8 for 100 further cycles.
- `ns_i` pulsed low for 2 cycles during ARMED → ignored; `t_o` timing unchanged from the first scenario.
- `ns_i` driven low for 10 cycles during ALERT → IDLE exactly 6 cycles after the falling edge, with `t_o`=0 and `second_o`=0. Re-raising `ns_i` restarts the count from 0.
- `rst_i` pulsed mid-ALERT between clock edges → `t_o`, `second_o`, `state_o` and `beep_o` are 0 before the next edge.
- With `BELT_WARN_BEEP_EN` defined → `beep_o` toggles every 5 cycles throughout ALERT and is 0 in HOLD. Without the macro, `beep_o` stays 0 for the whole run.
